// File: rtl/data_mem_rr_pkg.sv
// Shared definitions for data_mem_rr: region decode position, special
// shared-word indices and the per-core access classification.
package dmem_pkg;

    localparam int GPIN_IDX  = 0;
    localparam int GPOUT_IDX = 1;
    localparam int CNT_IDX   = 2;
    localparam int CNT_W     = 16;

    typedef enum logic [1:0] {
        IDLE,
        PRIV,
        SHARED
    } accType_e;

    // Address bit that selects private (0) or shared (1) RAM.
    function automatic int regionBit(input int lmem);
        return lmem;
    endfunction

endpackage

// File: rtl/data_mem_rr_if.sv
// Core-side load/store bus of data_mem_rr, NCORES channels packed per core.
// master: req/we/addr/wdata out, rdata/ack in. slave: the memory side.
interface data_mem_rr_if #(
    parameter int NCORES = 2,
    parameter int TAM    = 16
);
    logic [NCORES-1:0]     req;
    logic [NCORES-1:0]     we;
    logic [NCORES*TAM-1:0] addr;
    logic [NCORES*TAM-1:0] wdata;
    logic [NCORES*TAM-1:0] rdata;
    logic [NCORES-1:0]     ack;

    modport master (
        output req, we, addr, wdata,
        input  rdata, ack
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, ack
    );
endinterface

// File: rtl/data_mem_rr_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr.
// Ports: clk, rst (sync, active-low), reqVec in, grant (one-hot), ptr out.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  reqVec,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] ptr
);
    logic [PW-1:0] nextPtr;

    function automatic logic [PW-1:0] wrap(input int v);
        return PW'(v % N);
    endfunction

    // Scan from the farthest offset down so the nearest requester wins.
    always_comb begin
        grant   = '0;
        nextPtr = ptr;
        for (int k = N - 1; k >= 0; k--) begin
            if (reqVec[wrap(int'(ptr) + k)]) begin
                grant                       = '0;
                grant[wrap(int'(ptr) + k)]  = 1'b1;
                nextPtr                     = wrap(int'(ptr) + k + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr <= '0;
        end else if (|reqVec) begin
            ptr <= nextPtr;
        end
    end
endmodule

// File: rtl/data_mem_rr.sv
// Multi-core data memory: private RAM per core plus one arbitrated shared
// RAM holding GPIO words. Ports: clk, rst (sync, active-low), bus (slave
// modport of data_mem_rr_if), gpin, gpout. Optional macro
// DMEM_CONFLICT_CNT_EN maps a saturating contention counter at index 2.
module data_mem_rr
    import dmem_pkg::*;
#(
    parameter int NCORES     = 2,
    parameter int LMEM       = 8,
    parameter int TAM        = 16,
    parameter int GPIN_ADDR  = GPIN_IDX,
    parameter int GPOUT_ADDR = GPOUT_IDX
) (
    input  logic           clk,
    input  logic           rst,
    data_mem_rr_if.slave   bus,
    input  logic [TAM-1:0] gpin,
    output logic [TAM-1:0] gpout
);
    localparam int SW = 1 << LMEM;
    localparam int RB = regionBit(LMEM);
    localparam int PW = (NCORES > 1) ? $clog2(NCORES) : 1;
    localparam logic [LMEM-1:0] GI = LMEM'(GPIN_ADDR);
    localparam logic [LMEM-1:0] GO = LMEM'(GPOUT_ADDR);

    accType_e          kind      [NCORES];
    logic [LMEM-1:0]   wordIdx   [NCORES];
    logic [TAM-1:0]    storeData [NCORES];
    logic [TAM-1:0]    privRd    [NCORES];
    logic [NCORES-1:0] shReq;
    logic [NCORES-1:0] grant;
    logic [PW-1:0]     arbPtr;

    logic              shAny;
    logic              shWe;
    logic              shStore;
    logic [LMEM-1:0]   shIdx;
    logic [TAM-1:0]    shWd;
    logic [TAM-1:0]    shRd;
    logic              isGpin;
    logic              isGpout;
    logic              isCnt;
    logic [TAM-1:0]    shMem [SW];
    logic [TAM-1:0]    gpinReg;
    logic [TAM-1:0]    gpoutWord;

    logic [NCORES*TAM-1:0] rdataQ;
    logic [NCORES-1:0]     ackQ;
    logic                  unusedBits;

    // Address bits above the region bit are don't-care.
    assign unusedBits = ^{bus.addr, arbPtr};

    always_comb begin
        for (int i = 0; i < NCORES; i++) begin
            kind[i]      = IDLE;
            wordIdx[i]   = bus.addr[i*TAM +: LMEM];
            storeData[i] = bus.wdata[i*TAM +: TAM];
            if (bus.req[i]) begin
                kind[i] = bus.addr[i*TAM + RB] ? SHARED : PRIV;
            end
            shReq[i] = (kind[i] == SHARED);
        end
    end

    for (genvar g = 0; g < NCORES; g++) begin : gPriv
        logic [TAM-1:0] mem [SW];

        always_ff @(posedge clk) begin
            if (rst && kind[g] == PRIV && bus.we[g]) begin
                mem[wordIdx[g]] <= storeData[g];
            end
        end

        assign privRd[g] = mem[wordIdx[g]];
    end

    rr_arbiter #(
        .N (NCORES)
    ) uArb (
        .clk    (clk),
        .rst    (rst),
        .reqVec (shReq),
        .grant  (grant),
        .ptr    (arbPtr)
    );

    // The single shared port follows the winning core.
    always_comb begin
        shAny = |grant;
        shWe  = 1'b0;
        shIdx = '0;
        shWd  = '0;
        for (int i = 0; i < NCORES; i++) begin
            if (grant[i]) begin
                shWe  = bus.we[i];
                shIdx = wordIdx[i];
                shWd  = storeData[i];
            end
        end
    end

    assign shStore = rst && shAny && shWe;
    assign isGpin  = (shIdx == GI);
    assign isGpout = (shIdx == GO);

`ifdef DMEM_CONFLICT_CNT_EN
    localparam logic [LMEM-1:0] CI = LMEM'(CNT_IDX);
    logic [CNT_W-1:0] conflictCnt;
    logic [TAM-1:0]   cntWord;

    assign isCnt   = (shIdx == CI);
    assign cntWord = TAM'(conflictCnt);

    // Clear has priority over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (!rst) begin
            conflictCnt <= '0;
        end else if (shStore && isCnt) begin
            conflictCnt <= '0;
        end else if ((|(shReq & ~grant)) && (conflictCnt != '1)) begin
            conflictCnt <= conflictCnt + 1'b1;
        end
    end
`else
    assign isCnt = 1'b0;
`endif

    // GPIO and counter words live outside the RAM array.
    always_ff @(posedge clk) begin
        if (shStore && !isGpin && !isGpout && !isCnt) begin
            shMem[shIdx] <= shWd;
        end
    end

    always_comb begin
        shRd = shMem[shIdx];
`ifdef DMEM_CONFLICT_CNT_EN
        if (isCnt) begin
            shRd = cntWord;
        end
`endif
        if (isGpout) begin
            shRd = gpoutWord;
        end
        if (isGpin) begin
            shRd = gpinReg;
        end
    end

    always_ff @(posedge clk) begin
        gpinReg <= gpin;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rdataQ    <= '0;
            ackQ      <= '0;
            gpoutWord <= '0;
            gpout     <= '0;
        end else begin
            gpout <= gpoutWord;
            if (shStore && isGpout) begin
                gpoutWord <= shWd;
            end
            for (int i = 0; i < NCORES; i++) begin
                ackQ[i] <= (kind[i] == PRIV) || grant[i];
                if (kind[i] == PRIV && !bus.we[i]) begin
                    rdataQ[i*TAM +: TAM] <= privRd[i];
                end else if (grant[i] && !bus.we[i]) begin
                    rdataQ[i*TAM +: TAM] <= shRd;
                end
            end
        end
    end

    assign bus.rdata = rdataQ;
    assign bus.ack   = ackQ;
endmodule
